i2c_config_sequencer: RTL and testbench

//  Walks a fixed table of 24-bit I2C write entries {slave_addr[7:0], reg_data[15:0]}.

---
 rtl/i2c_config_sequencer_pkg.sv | 27 ++
 rtl/i2c_config_sequencer_rom.sv | 62 ++++++
 rtl/i2c_config_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_config_sequencer_pkg.sv
// Shared types and board constants for the I2C power-up configuration sequencer.
// Holds the FSM state encoding, the 24-bit table entry type and slave addresses.
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STARTUP,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_END,
    ST_RELEASE,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } cfg_state_t;

  typedef logic [23:0] cfg_entry_t;

  localparam logic       W_R_WRITE    = 1'b0;
  localparam logic [7:0] HDMI_TX_ADDR = 8'h72;
  localparam logic [7:0] CODEC_ADDR   = 8'h34;

  function automatic cfg_entry_t make_entry(input logic [7:0] addr, input logic [15:0] val);
    return {addr, val};
  endfunction

endpackage

// File: rtl/i2c_config_sequencer_rom.sv
// Board configuration table: HDMI transmitter bring-up followed by audio codec setup.
// Case-table ROM with a registered output (one cycle of read latency).
module i2c_config_rom
  import i2c_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES = 32,
  parameter int ADDR_W      = $clog2(NUM_ENTRIES + 1)
) (
  input  logic              CLOCK,
  input  logic [ADDR_W-1:0] addr,
  output cfg_entry_t        data
);

  cfg_entry_t data_reg;

  function automatic cfg_entry_t rom_entry(input int unsigned idx);
    cfg_entry_t e;
    case (idx)
      0:       e = make_entry(HDMI_TX_ADDR, 16'h4110);  // power up transmitter
      1:       e = make_entry(HDMI_TX_ADDR, 16'h9803);
      2:       e = make_entry(HDMI_TX_ADDR, 16'h9AE0);
      3:       e = make_entry(HDMI_TX_ADDR, 16'h9C30);
      4:       e = make_entry(HDMI_TX_ADDR, 16'h9D61);
      5:       e = make_entry(HDMI_TX_ADDR, 16'hA2A4);
      6:       e = make_entry(HDMI_TX_ADDR, 16'hA3A4);
      7:       e = make_entry(HDMI_TX_ADDR, 16'hE0D0);
      8:       e = make_entry(HDMI_TX_ADDR, 16'hF900);
      9:       e = make_entry(HDMI_TX_ADDR, 16'h1500);
      10:      e = make_entry(HDMI_TX_ADDR, 16'h1630);
      11:      e = make_entry(HDMI_TX_ADDR, 16'h1702);
      12:      e = make_entry(HDMI_TX_ADDR, 16'h1846);
      13:      e = make_entry(HDMI_TX_ADDR, 16'hAF06);
      14:      e = make_entry(HDMI_TX_ADDR, 16'h0A01);
      15:      e = make_entry(HDMI_TX_ADDR, 16'h0C04);
      16:      e = make_entry(CODEC_ADDR,   16'h1E00);  // codec soft reset first
      17:      e = make_entry(CODEC_ADDR,   16'h0C10);
      18:      e = make_entry(CODEC_ADDR,   16'h0E42);
      19:      e = make_entry(CODEC_ADDR,   16'h1000);
      20:      e = make_entry(CODEC_ADDR,   16'h0A06);
      21:      e = make_entry(CODEC_ADDR,   16'h0812);
      22:      e = make_entry(CODEC_ADDR,   16'h0017);
      23:      e = make_entry(CODEC_ADDR,   16'h0217);
      24:      e = make_entry(CODEC_ADDR,   16'h0479);
      25:      e = make_entry(CODEC_ADDR,   16'h0679);
      26:      e = make_entry(CODEC_ADDR,   16'h0C00);
      27:      e = make_entry(CODEC_ADDR,   16'h1201);  // activate digital interface last
      28:      e = make_entry(HDMI_TX_ADDR, 16'h3B80);
      29:      e = make_entry(HDMI_TX_ADDR, 16'h5510);
      30:      e = make_entry(HDMI_TX_ADDR, 16'h5608);
      31:      e = make_entry(HDMI_TX_ADDR, 16'h4110);
      default: e = '0;
    endcase
    return e;
  endfunction

  always_ff @(posedge CLOCK) begin
    data_reg <= rom_entry(32'(addr));
  end

  assign data = data_reg;

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the board configuration table after reset, issuing one I2C write per entry.
// Define I2C_CFG_RETRY_EN to re-issue NACKed entries up to MAX_RETRY times.
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES    = 32,
  parameter int STARTUP_CYCLES = 50000,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int MAX_RETRY      = 3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        restart,
  output logic [23:0] i2c_data,
  output logic        i2c_go,
  output logic        i2c_w_r,
  input  logic        i2c_end,
  input  logic        i2c_ack,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [7:0]  err_index
);

  localparam int IDX_W        = $clog2(NUM_ENTRIES + 1);
  localparam int STARTUP_LAST = (STARTUP_CYCLES > 1) ? STARTUP_CYCLES - 1 : 0;
  localparam int GAP_LAST     = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
  localparam int TIMEOUT_LAST = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int CNT_MAX_A    = (STARTUP_LAST > GAP_LAST) ? STARTUP_LAST : GAP_LAST;
  localparam int CNT_MAX      = (CNT_MAX_A > TIMEOUT_LAST) ? CNT_MAX_A : TIMEOUT_LAST;
  localparam int CNT_W        = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  if (NUM_ENTRIES < 1 || NUM_ENTRIES > 256 || GAP_CYCLES < 1 || MAX_RETRY < 0) begin : g_bad_param
    $error("i2c_config_sequencer: parameter out of range");
  end

  cfg_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  index_reg, index_next;
  cfg_entry_t        data_reg, data_next;
  logic              go_reg, go_next;
  logic              ack_reg, ack_next;
  logic [7:0]        err_index_reg, err_index_next;
  cfg_entry_t        rom_data;

`ifdef I2C_CFG_RETRY_EN
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RTY_W-1:0]  retry_reg, retry_next;

  always_ff @(posedge CLOCK) begin
    if (RESET) retry_reg <= '0;
    else       retry_reg <= retry_next;
  end
`endif

  i2c_config_rom #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ADDR_W      (IDX_W)
  ) u_rom (
    .CLOCK (CLOCK),
    .addr  (index_reg),
    .data  (rom_data)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg     <= ST_STARTUP;
      cnt_reg       <= '0;
      index_reg     <= '0;
      data_reg      <= '0;
      go_reg        <= 1'b0;
      ack_reg       <= 1'b0;
      err_index_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      index_reg     <= index_next;
      data_reg      <= data_next;
      go_reg        <= go_next;
      ack_reg       <= ack_next;
      err_index_reg <= err_index_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    index_next     = index_reg;
    data_next      = data_reg;
    go_next        = go_reg;
    ack_next       = ack_reg;
    err_index_next = err_index_reg;
`ifdef I2C_CFG_RETRY_EN
    retry_next     = retry_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (restart) begin
          index_next = '0;
          cnt_next   = '0;
`ifdef I2C_CFG_RETRY_EN
          retry_next = '0;
`endif
          state_next = ST_STARTUP;
        end
      end
      ST_STARTUP: begin
        if (cnt_reg >= CNT_W'(STARTUP_LAST)) begin
          cnt_next   = '0;
          state_next = ST_LOAD;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        data_next  = rom_data;
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        // A stale END from the previous transfer must clear before a new request.
        if (!i2c_end) begin
          go_next    = 1'b1;
          cnt_next   = '0;
          state_next = ST_WAIT_END;
        end
      end
      ST_WAIT_END: begin
        if (i2c_end) begin
          ack_next   = i2c_ack;
          go_next    = 1'b0;
          state_next = ST_RELEASE;
        end else if (cnt_reg >= CNT_W'(TIMEOUT_LAST)) begin
          go_next        = 1'b0;
          err_index_next = 8'(index_reg);
          state_next     = ST_ERROR;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!i2c_end) begin
          cnt_next = '0;
          if (ack_reg) begin
`ifdef I2C_CFG_RETRY_EN
            retry_next = '0;
`endif
            if (index_reg == LAST_IDX) begin
              state_next = ST_DONE;
            end else begin
              index_next = index_reg + IDX_W'(1);
              state_next = ST_GAP;
            end
          end else begin
`ifdef I2C_CFG_RETRY_EN
            if (retry_reg < RTY_W'(MAX_RETRY)) begin
              retry_next = retry_reg + RTY_W'(1);
              state_next = ST_GAP;
            end else begin
              err_index_next = 8'(index_reg);
              state_next     = ST_ERROR;
            end
`else
            err_index_next = 8'(index_reg);
            state_next     = ST_ERROR;
`endif
          end
        end
      end
      ST_GAP: begin
        if (cnt_reg >= CNT_W'(GAP_LAST)) begin
          cnt_next   = '0;
          state_next = ST_LOAD;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign i2c_data  = data_reg;
  assign i2c_go    = go_reg;
  assign i2c_w_r   = W_R_WRITE;
  assign busy      = !(state_reg == ST_IDLE || state_reg == ST_DONE || state_reg == ST_ERROR);
  assign cfg_done  = (state_reg == ST_DONE);
  assign cfg_error = (state_reg == ST_ERROR);
  assign err_index = err_index_reg;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: behavioural I2C controller (END 40 cycles after GO,
// per-issue programmable ACK), table of ACK scenarios plus restart/timeout/reset sequences.
module tb_i2c_config_sequencer;

  logic        CLOCK   = 1'b0;
  logic        RESET   = 1'b1;
  logic        restart = 1'b0;
  logic        i2c_end = 1'b0;
  logic        i2c_ack = 1'b0;
  logic [23:0] i2c_data;
  logic        i2c_go, i2c_w_r, busy, cfg_done, cfg_error;
  logic [7:0]  err_index;

  i2c_config_sequencer #(
    .NUM_ENTRIES    (4),
    .STARTUP_CYCLES (10),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (100),
    .MAX_RETRY      (3)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .restart   (restart),
    .i2c_data  (i2c_data),
    .i2c_go    (i2c_go),
    .i2c_w_r   (i2c_w_r),
    .i2c_end   (i2c_end),
    .i2c_ack   (i2c_ack),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error),
    .err_index (err_index)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  // Controller model state
  int          go_count  = 0;
  int          go_cyc    = 0;
  int          data_bad  = 0;
  logic        go_prev   = 1'b0;
  bit          never_end = 1'b0;
  logic        ack_plan [256];
  logic [23:0] go_log   [256];

  always @(negedge CLOCK) begin
    if (RESET) begin
      i2c_end = 1'b0;
      i2c_ack = 1'b0;
      go_cyc  = 0;
    end else begin
      if (i2c_go && !go_prev && go_count < 256) begin
        go_log[go_count] = i2c_data;
        go_count++;
        go_cyc = 0;
      end
      if (i2c_go) begin
        if (i2c_data !== go_log[go_count-1]) data_bad++;
        if (!i2c_end) begin
          go_cyc++;
          if (go_cyc == 40 && !never_end) begin
            i2c_end = 1'b1;
            i2c_ack = ack_plan[go_count-1];
          end
        end
      end else begin
        i2c_end = 1'b0;
      end
    end
    go_prev = i2c_go;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_restart();
    @(negedge CLOCK) restart = 1'b1;
    @(negedge CLOCK) restart = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 3000 && busy; c++) @(negedge CLOCK);
    check({name, " finished"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_go(input string name, input logic level);
    for (int c = 0; c < 500 && i2c_go !== level; c++) @(negedge CLOCK);
    check({name, " go level"}, 32'(i2c_go), 32'(level));
  endtask

  typedef struct {
    string      name;
    logic [7:0] plan;   // bit k = ACK returned for the k-th issue of the run
    string      seq;    // entry index of each expected issue, in order
    logic       done;
    logic [7:0] eidx;
  } vec_t;

  vec_t        vecs[6];
  logic [23:0] exp_rom[4] = '{24'h724110, 24'h729803, 24'h729AE0, 24'h729C30};

  initial begin
    int base;
    int r_cyc;

    vecs[0] = '{"all_ack",   8'b1111_1111, "0123",   1'b1, 8'd0};
`ifdef I2C_CFG_RETRY_EN
    vecs[1] = '{"nack_e2",   8'b1111_1011, "01223",  1'b1, 8'd0};
    vecs[2] = '{"e1_nack2",  8'b1111_1001, "011123", 1'b1, 8'd0};
    vecs[3] = '{"e1_nack4",  8'b1110_0001, "01111",  1'b0, 8'd1};
    vecs[4] = '{"nack_e0",   8'b1111_1110, "00123",  1'b1, 8'd0};
    vecs[5] = '{"nack_e3",   8'b1111_0111, "01233",  1'b1, 8'd0};
`else
    vecs[1] = '{"nack_e2",   8'b1111_1011, "012",    1'b0, 8'd2};
    vecs[2] = '{"e1_nack2",  8'b1111_1001, "01",     1'b0, 8'd1};
    vecs[3] = '{"e1_nack4",  8'b1110_0001, "01",     1'b0, 8'd1};
    vecs[4] = '{"nack_e0",   8'b1111_1110, "0",      1'b0, 8'd0};
    vecs[5] = '{"nack_e3",   8'b1111_0111, "0123",   1'b0, 8'd3};
`endif
    for (int k = 0; k < 256; k++) ack_plan[k] = 1'b1;

    repeat (3) @(negedge CLOCK);
    check("reset go",        32'(i2c_go),    32'd0);
    check("reset data",      32'(i2c_data),  32'd0);
    check("reset w_r",       32'(i2c_w_r),   32'd0);
    check("reset busy",      32'(busy),      32'd1);
    check("reset done",      32'(cfg_done),  32'd0);
    check("reset error",     32'(cfg_error), 32'd0);
    check("reset err_index", 32'(err_index), 32'd0);

    for (int i = 0; i < 6; i++) begin
      base = go_count;
      for (int k = 0; k < 8; k++) ack_plan[base+k] = vecs[i].plan[k];
      if (i == 0) begin
        @(negedge CLOCK) RESET = 1'b0;
      end else begin
        pulse_restart();
        check($sformatf("%s restart clears done", vecs[i].name),  32'(cfg_done),  32'd0);
        check($sformatf("%s restart clears error", vecs[i].name), 32'(cfg_error), 32'd0);
        check($sformatf("%s restart busy", vecs[i].name),         32'(busy),      32'd1);
      end
      wait_idle(vecs[i].name);
      check($sformatf("%s go pulses", vecs[i].name), 32'(go_count - base), 32'(vecs[i].seq.len()));
      check($sformatf("%s done", vecs[i].name),  32'(cfg_done),  32'(vecs[i].done));
      check($sformatf("%s error", vecs[i].name), 32'(cfg_error), 32'(!vecs[i].done));
      if (!vecs[i].done)
        check($sformatf("%s err_index", vecs[i].name), 32'(err_index), 32'(vecs[i].eidx));
      for (int k = 0; k < vecs[i].seq.len() && base + k < go_count; k++) begin
        int e;
        e = int'(vecs[i].seq[k]) - 48;
        check($sformatf("%s issue %0d data", vecs[i].name, k), 32'(go_log[base+k]), 32'(exp_rom[e]));
      end
      repeat (60) @(negedge CLOCK);
      check($sformatf("%s no go after end", vecs[i].name), 32'(go_count - base), 32'(vecs[i].seq.len()));
      $display("vector %s: %0d issues, done=%0b error=%0b err_index=%0d",
               vecs[i].name, go_count - base, cfg_done, cfg_error, err_index);
    end

    // restart while a transfer is outstanding must be ignored
    base = go_count;
    for (int k = 0; k < 8; k++) ack_plan[base+k] = 1'b1;
    pulse_restart();
    wait_go("busy_restart", 1'b1);
    repeat (5) @(negedge CLOCK);
    pulse_restart();
    check("busy_restart go held", 32'(i2c_go), 32'd1);
    wait_idle("busy_restart");
    check("busy_restart go pulses", 32'(go_count - base), 32'd4);
    check("busy_restart done",      32'(cfg_done),        32'd1);
    $display("sequence busy_restart: %0d issues, done=%0b", go_count - base, cfg_done);

    // controller never answers: go must drop exactly TIMEOUT cycles after it rose
    never_end = 1'b1;
    base = go_count;
    pulse_restart();
    wait_go("timeout rise", 1'b1);
    r_cyc = cyc;
    wait_go("timeout fall", 1'b0);
    check("timeout go width",  32'(cyc - r_cyc),      32'd100);
    check("timeout error",     32'(cfg_error),        32'd1);
    check("timeout err_index", 32'(err_index),        32'd0);
    check("timeout busy",      32'(busy),             32'd0);
    check("timeout go pulses", 32'(go_count - base),  32'd1);
    never_end = 1'b0;
    $display("sequence timeout: go width %0d cycles, err_index=%0d", cyc - r_cyc, err_index);

    // reset while go is high
    pulse_restart();
    wait_go("reset_mid rise", 1'b1);
    repeat (3) @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    check("reset_mid go",    32'(i2c_go),    32'd0);
    check("reset_mid busy",  32'(busy),      32'd1);
    check("reset_mid error", 32'(cfg_error), 32'd0);
    check("reset_mid data",  32'(i2c_data),  32'd0);
    RESET = 1'b0;
    base = go_count;
    for (int k = 0; k < 8; k++) ack_plan[base+k] = 1'b1;
    wait_idle("reset_mid");
    check("reset_mid go pulses",  32'(go_count - base), 32'd4);
    check("reset_mid done",       32'(cfg_done),        32'd1);
    check("reset_mid first data", 32'(go_log[base]),    32'(exp_rom[0]));
    $display("sequence reset_mid: %0d issues after reset, done=%0b", go_count - base, cfg_done);

    check("data stable while go", 32'(data_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
